// File: rtl/disp_rd_scheduler_pkg.sv
// Shared types for the display frame-read scheduler.
package disp_rd_scheduler_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StCheck,
        StReq,
        StWaitDone,
        StDone
    } state_e;

    // Smaller of a full burst and the words still owed for the frame.
    function automatic logic [31:0] burst_words(input logic [31:0] words_left,
                                                input logic [31:0] burst_len);
        return (words_left >= burst_len) ? burst_len : words_left;
    endfunction

endpackage

// File: rtl/disp_frame_sync.sv
// Registered rising-edge detector for the display vsync (frame start).
module disp_frame_sync (
    input  logic i_pixel_clock,
    input  logic i_reset_n,
    input  logic i_rd_load,
    output logic o_start
);

    logic r_load_prev;

    // Remember last cycle's vsync level so each rising edge yields one start.
    always_ff @(posedge i_pixel_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_load_prev <= 1'b0;
        end else begin
            r_load_prev <= i_rd_load;
        end
    end

    assign o_start = i_rd_load & ~r_load_prev;

endmodule

// File: rtl/disp_rd_scheduler.sv
// Frame-read scheduler: keeps the display rd_fifo fed with burst reads of one frame.
module disp_rd_scheduler
    import disp_rd_scheduler_pkg::*;
#(
    parameter int unsigned SOURCE_H   = 800,
    parameter int unsigned SOURCE_V   = 480,
    parameter int unsigned ADDR_W     = 28,
    parameter int unsigned BURST_LEN  = 64,
    parameter int unsigned LEN_W      = 9,
    parameter int unsigned FIFO_DEPTH = 1024,
    parameter int unsigned CNT_W      = 11,
    parameter int unsigned ADDR_STEP  = 4,
    parameter int unsigned FLUSH_CYC  = 4
) (
    input  logic              i_pixel_clock,
    input  logic              i_reset_n,
    input  logic              i_rd_load,
    input  logic [ADDR_W-1:0] i_frame_base,
    input  logic [CNT_W-1:0]  i_fifo_wrusedw,
    output logic              o_fifo_flush,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [LEN_W-1:0]  o_rd_len,
    input  logic              i_rd_ack,
    input  logic              i_rd_done,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_frame_short
);

    localparam int unsigned FRAME_WORDS = SOURCE_H * SOURCE_V;
    localparam int unsigned WL_W        = $clog2(FRAME_WORDS + 1);
    localparam int unsigned FC_W        = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    state_e            r_state;
    state_e            w_state_d;
    logic [FC_W-1:0]   r_flush_cnt;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [WL_W-1:0]   r_words_left;
    logic              r_pend;
    logic              r_frame_done;
    logic              r_frame_short;

    logic              w_start;
    logic              w_load;
    logic              w_advance;
    logic              w_set_pend;
    logic              w_clr_pend;
    logic              w_done_d;
    logic              w_short_d;
    logic              w_room;
    logic [31:0]       w_len_words;

    disp_frame_sync u_frame_sync (
        .i_pixel_clock (i_pixel_clock),
        .i_reset_n     (i_reset_n),
        .i_rd_load     (i_rd_load),
        .o_start       (w_start)
    );

    assign w_len_words = burst_words(32'(r_words_left), BURST_LEN);
    assign w_room      = (32'(i_fifo_wrusedw) + BURST_LEN) <= FIFO_DEPTH;

    // Next-state decode; a frame start never withdraws an issued request, it is deferred via pend.
    always_comb begin
        w_state_d  = r_state;
        w_load     = 1'b0;
        w_advance  = 1'b0;
        w_set_pend = 1'b0;
        w_clr_pend = 1'b0;
        w_done_d   = 1'b0;
        w_short_d  = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (w_start) begin
                    w_state_d = StFlush;
                    w_load    = 1'b1;
                end
            end
            StFlush: begin
                if (w_start) begin
                    w_load = 1'b1;
                end else if (r_flush_cnt == FC_W'(FLUSH_CYC - 1)) begin
                    w_state_d = StCheck;
                end
            end
            StCheck: begin
                if (w_start) begin
                    w_state_d = StFlush;
                    w_load    = 1'b1;
                    w_short_d = (r_words_left != '0);
                end else if (r_words_left == '0) begin
                    w_state_d = StDone;
                    w_done_d  = 1'b1;
                end else if (w_room) begin
                    w_state_d = StReq;
                end
            end
            StReq: begin
                if (w_start) begin
                    w_set_pend = 1'b1;
                    w_short_d  = 1'b1;
                end
                if (i_rd_ack) begin
                    w_advance = 1'b1;
                    if (!i_rd_done) begin
                        w_state_d = StWaitDone;
                    end else if (r_pend || w_start) begin
                        w_state_d  = StFlush;
                        w_load     = 1'b1;
                        w_clr_pend = 1'b1;
                    end else begin
                        w_state_d = StCheck;
                    end
                end
            end
            StWaitDone: begin
                if (w_start) begin
                    w_set_pend = 1'b1;
                    w_short_d  = 1'b1;
                end
                if (i_rd_done) begin
                    if (r_pend || w_start) begin
                        w_state_d  = StFlush;
                        w_load     = 1'b1;
                        w_clr_pend = 1'b1;
                    end else begin
                        w_state_d = StCheck;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State, counters and registered status pulses.
    always_ff @(posedge i_pixel_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_flush_cnt   <= '0;
            r_cur_addr    <= '0;
            r_words_left  <= '0;
            r_pend        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_short <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_frame_done  <= w_done_d;
            r_frame_short <= w_short_d;
            if (w_load) begin
                r_flush_cnt  <= '0;
                r_cur_addr   <= i_frame_base;
                r_words_left <= WL_W'(FRAME_WORDS);
            end else begin
                if (r_state == StFlush) begin
                    r_flush_cnt <= r_flush_cnt + FC_W'(1);
                end
                if (w_advance) begin
                    r_cur_addr   <= r_cur_addr + ADDR_W'(w_len_words * ADDR_STEP);
                    r_words_left <= r_words_left - WL_W'(w_len_words);
                end
            end
            if (w_clr_pend) begin
                r_pend <= 1'b0;
            end else if (w_set_pend) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign o_fifo_flush  = (r_state == StFlush);
    assign o_rd_req      = (r_state == StReq);
    assign o_rd_addr     = o_rd_req ? r_cur_addr : '0;
    assign o_rd_len      = o_rd_req ? LEN_W'(w_len_words) : '0;
    assign o_busy        = (r_state != StIdle) && (r_state != StDone);
    assign o_frame_done  = r_frame_done;
    assign o_frame_short = r_frame_short;

    // Request fields must hold until the arbiter accepts them.
    a_req_stable: assert property (@(posedge i_pixel_clock) disable iff (!i_reset_n)
        (o_rd_req && !i_rd_ack) |=> ($stable(o_rd_addr) && $stable(o_rd_len)));

    // Never read into a FIFO that is being cleared.
    a_flush_req_excl: assert property (@(posedge i_pixel_clock) disable iff (!i_reset_n)
        !(o_fifo_flush && o_rd_req));

endmodule

// File: tb/tb_disp_rd_scheduler.sv
// Self-checking bench: cycle-level behavioural model plus directed literal pins and random traffic.
module tb_disp_rd_scheduler;

    localparam int unsigned H          = 20;
    localparam int unsigned V          = 15;
    localparam int unsigned FW         = H * V;
    localparam int unsigned ADDR_W     = 28;
    localparam int unsigned BURST_LEN  = 64;
    localparam int unsigned LEN_W      = 9;
    localparam int unsigned FIFO_DEPTH = 1024;
    localparam int unsigned CNT_W      = 11;
    localparam int unsigned ADDR_STEP  = 4;
    localparam int unsigned FLUSH_CYC  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rd_load = 1'b0;
    logic [ADDR_W-1:0] frame_base = '0;
    logic [CNT_W-1:0]  wrusedw = '0;
    logic              rd_ack = 1'b0;
    logic              rd_done = 1'b0;
    logic              fifo_flush, rd_req, busy, frame_done, frame_short;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_len;

    always #5 clk = ~clk;

    disp_rd_scheduler #(
        .SOURCE_H   (H),
        .SOURCE_V   (V),
        .ADDR_W     (ADDR_W),
        .BURST_LEN  (BURST_LEN),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W),
        .ADDR_STEP  (ADDR_STEP),
        .FLUSH_CYC  (FLUSH_CYC)
    ) dut (
        .i_pixel_clock  (clk),
        .i_reset_n      (rst_n),
        .i_rd_load      (rd_load),
        .i_frame_base   (frame_base),
        .i_fifo_wrusedw (wrusedw),
        .o_fifo_flush   (fifo_flush),
        .o_rd_req       (rd_req),
        .o_rd_addr      (rd_addr),
        .o_rd_len       (rd_len),
        .i_rd_ack       (rd_ack),
        .i_rd_done      (rd_done),
        .o_busy         (busy),
        .o_frame_done   (frame_done),
        .o_frame_short  (frame_short)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int                m_flush_left = 0;  // flush cycles still to show
    int                m_words = 0;       // words of the frame not yet requested
    logic [ADDR_W-1:0] m_addr = '0;
    bit                m_req = 0;         // request visible, not yet accepted
    bit                m_inflight = 0;    // accepted, waiting for last word
    bit                m_pend = 0;        // frame start seen during a burst
    bit                m_busy = 0;        // frame in progress
    bit                m_done_p = 0;
    bit                m_short_p = 0;
    bit                m_prev_load = 0;

    function automatic int m_len();
        return (m_words >= int'(BURST_LEN)) ? int'(BURST_LEN) : m_words;
    endfunction

    task automatic model_reset();
        m_flush_left = 0; m_words = 0; m_addr = '0; m_req = 0; m_inflight = 0;
        m_pend = 0; m_busy = 0; m_done_p = 0; m_short_p = 0; m_prev_load = 0;
    endtask

    task automatic model_step();
        bit st;
        bit reload;
        st = rd_load && !m_prev_load;
        m_prev_load = rd_load;
        reload = 0;
        m_done_p = 0;
        m_short_p = 0;
        if (m_flush_left > 0) begin
            if (st) reload = 1;
            else m_flush_left--;
        end else if (m_req) begin
            if (st) begin m_pend = 1; m_short_p = 1; end
            if (rd_ack) begin
                m_addr  = m_addr + ADDR_W'(m_len() * ADDR_STEP);
                m_words = m_words - m_len();
                m_req   = 0;
                if (!rd_done) m_inflight = 1;
                else if (m_pend) begin reload = 1; m_pend = 0; end
            end
        end else if (m_inflight) begin
            if (st) begin m_pend = 1; m_short_p = 1; end
            if (rd_done) begin
                m_inflight = 0;
                if (m_pend) begin reload = 1; m_pend = 0; end
            end
        end else if (m_busy) begin
            if (st) begin
                m_short_p = (m_words != 0);
                reload = 1;
            end else if (m_words == 0) begin
                m_busy = 0;
                m_done_p = 1;
            end else if (int'(wrusedw) + int'(BURST_LEN) <= int'(FIFO_DEPTH)) begin
                m_req = 1;
            end
        end else if (st) begin
            reload = 1;
        end
        if (reload) begin
            m_flush_left = FLUSH_CYC;
            m_words = FW;
            m_addr = frame_base;
            m_busy = 1;
        end
    endtask

    // Advance the model on every edge and compare all outputs just after it.
    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check("fifo_flush", 64'(fifo_flush), 64'(m_flush_left > 0));
        check("rd_req", 64'(rd_req), 64'(m_req));
        check("rd_addr", 64'(rd_addr), m_req ? 64'(m_addr) : 64'd0);
        check("rd_len", 64'(rd_len), m_req ? 64'(m_len()) : 64'd0);
        check("busy", 64'(busy), 64'(m_busy));
        check("frame_done", 64'(frame_done), 64'(m_done_p));
        check("frame_short", 64'(frame_short), 64'(m_short_p));
    end

    // ---------------- stimulus side ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        int                cyc;
    } burst_t;

    burst_t burst_q[$];
    int cyc = 0;
    int done_cnt = 0;
    int short_cnt = 0;
    int arb_state = 0;  // 0 idle, 1 waiting to ack, 2 waiting to signal done
    int arb_cnt = 0;
    int ack_lo = 2, ack_hi = 2, done_lo = 10, done_hi = 10;
    bit spurious = 0;
    bit rand_mode = 0;
    int load_hold = 0;

    task automatic arbiter();
        rd_ack = 1'b0;
        rd_done = 1'b0;
        if (!rst_n) begin
            arb_state = 0;
            return;
        end
        if (arb_state == 0 && rd_req) begin
            arb_state = 1;
            arb_cnt = int'($urandom_range(ack_hi, ack_lo));
        end
        if (arb_state == 1) begin
            if (arb_cnt == 0) begin
                rd_ack = 1'b1;
                burst_q.push_back('{addr: rd_addr, len: rd_len, cyc: cyc});
                arb_cnt = int'($urandom_range(done_hi, done_lo));
                if (arb_cnt == 0) begin
                    rd_done = 1'b1;
                    arb_state = 0;
                end else begin
                    arb_state = 2;
                end
            end else begin
                arb_cnt--;
            end
        end else if (arb_state == 2) begin
            arb_cnt--;
            if (arb_cnt == 0) begin
                rd_done = 1'b1;
                arb_state = 0;
            end
        end else if (spurious && !rd_req) begin
            rd_ack  = ($urandom_range(0, 15) == 0);
            rd_done = ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic random_inputs();
        if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 3))
                0: wrusedw = CNT_W'($urandom_range(0, 1023));
                1: wrusedw = 11'd960;
                2: wrusedw = 11'd961;
                default: wrusedw = '0;
            endcase
        end
        if (load_hold > 0) begin
            load_hold--;
            if (load_hold == 0) rd_load = 1'b0;
        end else if ($urandom_range(0, 149) == 0) begin
            rd_load = 1'b1;
            frame_base = ADDR_W'($urandom);
            load_hold = int'($urandom_range(1, 3));
        end
    endtask

    // One clock: inputs change on the falling edge only.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (frame_done) done_cnt++;
        if (frame_short) short_cnt++;
        arbiter();
        if (rand_mode) random_inputs();
    endtask

    task automatic wait_bursts(input int n, input string name);
        int k = 0;
        while (burst_q.size() < n && k < 3000) begin cycle(); k++; end
        check(name, 64'(burst_q.size() >= n), 64'd1);
    endtask

    task automatic wait_frame_done(input string name);
        int target = done_cnt + 1;
        int k = 0;
        while (done_cnt < target && k < 3000) begin cycle(); k++; end
        check(name, 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic start_frame(input logic [ADDR_W-1:0] base);
        frame_base = base;
        rd_load = 1'b1;
        cycle();
        rd_load = 1'b0;
    endtask

    task automatic check_frame_bursts(input string name, input logic [ADDR_W-1:0] base);
        check({name, "_count"}, 64'(burst_q.size()), 64'd5);
        for (int k = 0; k < burst_q.size() && k < 5; k++) begin
            check({name, "_addr"}, 64'(burst_q[k].addr), 64'(ADDR_W'(base + ADDR_W'(k * 256))));
            check({name, "_len"}, 64'(burst_q[k].len), (k < 4) ? 64'd64 : 64'd44);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        logic [ADDR_W-1:0] base;

        // Reset state
        repeat (3) cycle();
        check("reset_req", 64'(rd_req), 64'd0);
        check("reset_flush", 64'(fifo_flush), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        repeat (2) cycle();

        // Full frame at an empty FIFO: 4 full bursts and a 44-word tail
        base = 28'h100_0000;
        start_frame(base);
        check("flush_latency", 64'(fifo_flush), 64'd1);
        n = 1;
        repeat (7) begin cycle(); if (fifo_flush) n++; end
        check("flush_cycles", 64'(n), 64'd4);
        wait_frame_done("frame1_done_timeout");
        check_frame_bursts("frame1", base);
        check("frame1_done_cnt", 64'(done_cnt), 64'd1);
        repeat (3) cycle();
        check("idle_after_done", 64'(busy), 64'd0);

        // FIFO threshold: 961 blocks, 960 admits; base near the top wraps the address
        burst_q.delete();
        wrusedw = 11'd961;
        base = 28'hFFF_FF00;
        start_frame(base);
        n = 0;
        repeat (30) begin cycle(); if (rd_req) n++; end
        check("no_req_at_961", 64'(n), 64'd0);
        wrusedw = 11'd960;
        cycle();
        check("req_at_960", 64'(rd_req), 64'd1);
        wait_frame_done("frame2_done_timeout");
        check_frame_bursts("frame2_wrap", base);
        wrusedw = '0;

        // Frame start while a burst is in flight
        burst_q.delete();
        short_cnt = 0;
        start_frame(28'h020_0000);
        wait_bursts(1, "wd_first_ack_timeout");
        cycle();
        base = 28'h030_0000;
        start_frame(base);
        check("wd_short_pulse", 64'(frame_short), 64'd1);
        n = 0;
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            cycle();
            if (fifo_flush) seen = 1;
            else if (rd_req) n++;
        end
        check("wd_no_req_before_flush", 64'(n), 64'd0);
        check("wd_flush_seen", 64'(seen), 64'd1);
        n = 1;
        repeat (6) begin cycle(); if (fifo_flush) n++; end
        check("wd_flush_cycles", 64'(n), 64'd4);
        wait_bursts(2, "wd_second_ack_timeout");
        check("wd_restart_addr", 64'(burst_q[1].addr), 64'(base));
        check("wd_restart_len", 64'(burst_q[1].len), 64'd64);
        wait_frame_done("wd_done_timeout");
        check("wd_short_cnt", 64'(short_cnt), 64'd1);

        // rd_ack and rd_done together: next request follows without waiting
        burst_q.delete();
        done_lo = 0;
        done_hi = 0;
        base = 28'h040_0000;
        start_frame(base);
        wait_frame_done("same_done_timeout");
        check_frame_bursts("same", base);
        if (burst_q.size() >= 2) check("same_gap", 64'(burst_q[1].cyc - burst_q[0].cyc), 64'd4);

        // Reset while a request is pending
        ack_lo = 5; ack_hi = 5; done_lo = 3; done_hi = 3;
        start_frame(28'h050_0000);
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin cycle(); if (rd_req) seen = 1; end
        check("rst_req_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 64'(rd_req), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin cycle(); if (busy || rd_req || fifo_flush) n++; end
        check("idle_after_rst", 64'(n), 64'd0);
        start_frame(28'h060_0000);
        check("rst_new_frame_flush", 64'(fifo_flush), 64'd1);
        wait_frame_done("rst_done_timeout");

        // Random traffic against the model
        ack_lo = 0; ack_hi = 3; done_lo = 0; done_hi = 12;
        spurious = 1;
        rand_mode = 1;
        repeat (8000) cycle();
        rand_mode = 0;
        rd_load = 1'b0;
        repeat (5) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
